sd_sector_arbiter: RTL and testbench
====================================

SD_SECTOR_ARBITER -- requirements
Module: sd_sector_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32'd32000000, the clk cycles allowed per phase (START, XFER) before abort (1 s at 32 MHz).
REQ-002 SHALL have port clk  in  1  the single system clock (clk_32 domain); all logic is on the rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port rd  in  2  per-requester sector read request (bit0 = drive A, bit1 = drive B), level, held until ack falls.
REQ-005 SHALL have port lba0  in  32  sector address for requester 0, sampled at grant.
REQ-006 SHALL have port lba1  in  32  sector address for requester 1, sampled at grant.
REQ-007 SHALL have port ack  out  2  per-requester busy/acknowledge, one-hot or zero.
REQ-008 SHALL have port dout_strobe  out  2  per-requester byte-valid strobe.
REQ-009 SHALL have port dout  out  8  shared byte data, valid with dout_strobe.
REQ-010 SHALL have port buff_addr  out  9  shared byte index 0..511, valid with dout_strobe.
REQ-011 SHALL have port err  out  1  one-cycle pulse when a transfer ends abnormally.
REQ-012 SHALL have port rstart  out  1  read start to the SD FAT reader.
REQ-013 SHALL have port rsector  out  32  sector number to the SD FAT reader.
REQ-014 SHALL have port rbusy  in  1  reader busy.
REQ-015 SHALL have port rdone  in  1  reader done pulse.
REQ-016 SHALL have port outen  in  1  reader byte strobe.
REQ-017 SHALL have port outaddr  in  9  reader byte index.
REQ-018 SHALL have port outbyte  in  8  reader byte.

Function
REQ-019 SHALL implement FSM states IDLE, START, XFER, DONE.
REQ-020 IDLE: when rd != 0, SHALL grant one requester, latch its lba into rsector, and go to START next cycle; rd == 0 stays in IDLE.
REQ-021 Grant SHALL be round-robin: if both rd bits are set, grant the requester not served last; if one bit is set, grant it; last-served resets to 1, so requester 0 wins the first tie.
REQ-022 START: rstart SHALL be 1 and ack[grant] SHALL be 1; when rbusy == 1, go to XFER with rstart 0 in the same clock.
REQ-023 XFER: rstart SHALL be 0 and ack[grant] SHALL stay 1; each outen SHALL produce dout_strobe[grant] = 1 with dout = outbyte and buff_addr = outaddr, registered, latency exactly 1 cycle; dout_strobe[!grant] SHALL be 0.
REQ-024 XFER SHALL count outen pulses in a 10-bit counter cleared on entry to START.
REQ-025 On rdone in XFER, go to DONE; if rdone and outen arrive in the same cycle, the byte SHALL be forwarded and counted first.
REQ-026 At DONE entry, err SHALL pulse for one cycle if byte count != 512.
REQ-027 A phase timer SHALL clear on each state entry; timer reaching TIMEOUT in START or XFER SHALL force DONE with an err pulse; the timer SHALL not wrap.
REQ-028 DONE: ack SHALL be 0, last-served SHALL be updated to grant, and the FSM SHALL return to IDLE after exactly one cycle; rd[grant] still high in IDLE is treated as a new request.
REQ-029 A requester dropping rd during START/XFER SHALL not abort the transfer; bytes are still routed to it until DONE.
REQ-030 rsector SHALL be held stable from grant until the next grant.
REQ-031 rd changes or lba changes outside IDLE SHALL be ignored until the next IDLE.
REQ-032 Strobes SHALL be ignored when outen arrives in IDLE/START/DONE, with no dout_strobe and no count.

Reset
REQ-033 reset_n == 0 at a clock edge SHALL force IDLE, with rstart, ack, dout_strobe, err, rsector, dout, buff_addr, counters and timer all 0, and last-served = 1, regardless of state; this includes reset mid-transfer.
REQ-034 Outputs SHALL remain at reset values while reset_n is low, and the first grant SHALL be evaluated on the first edge with reset_n == 1.

Verification
REQ-035 Single read: rd = 01, lba0 = 0x10; reader raises rbusy 3 cycles later and sends 512 outen then rdone -> rsector = 0x10, ack = 01 through XFER, 512 dout_strobe[0] pulses each 1 cycle after outen, err never pulses, ack = 00 in DONE.
REQ-036 Tie fairness: rd = 11 held for 3 back-to-back transfers -> grant order 0, 1, 0, with rsector = lba0, lba1, lba0.
REQ-037 Short transfer: 500 outen then rdone -> err pulses exactly one cycle at DONE entry, and the FSM is in IDLE 1 cycle later.
REQ-038 Timeout with TIMEOUT = 100 and rbusy never set -> rstart high for 100 cycles, then DONE with err pulse, ack drops, and IDLE follows.
REQ-039 Reset mid-XFER after 200 bytes -> next cycle all outputs 0 and IDLE; with rd = 11 afterwards, requester 0 is granted.
REQ-040 Same-cycle rdone and 512th outen -> byte forwarded, count = 512, no err.

Source files
------------

// File: rtl/sd_sector_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : sd_sector_arbiter
// Description : Round-robin arbiter sharing one SD FAT sector reader between
//               two requesters, with byte routing, count check and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_sector_arbiter #(
  parameter logic [31:0] TIMEOUT = 32'd32000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  rd,
  input  logic [31:0] lba0,
  input  logic [31:0] lba1,
  output logic [1:0]  ack,
  output logic [1:0]  dout_strobe,
  output logic [7:0]  dout,
  output logic [8:0]  buff_addr,
  output logic        err,
  output logic        rstart,
  output logic [31:0] rsector,
  input  logic        rbusy,
  input  logic        rdone,
  input  logic        outen,
  input  logic [8:0]  outaddr,
  input  logic [7:0]  outbyte
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [31:0] rsector_q, rsector_d;
  logic [31:0] timer_q, timer_d;
  logic [9:0]  count_q, count_d;
  logic [1:0]  strobe_q, strobe_d;
  logic [7:0]  dout_q, dout_d;
  logic [8:0]  baddr_q, baddr_d;
  logic        err_q, err_d;

  logic        w_pick;
  logic        w_timeout;
  logic [31:0] w_timer_inc;
  logic [9:0]  w_count_inc;
  logic [1:0]  w_grant_onehot;

  // On a tie the requester not served last wins.
  assign w_pick         = (rd == 2'b11) ? ~last_q : rd[1];
  assign w_timer_inc    = (timer_q == 32'hFFFF_FFFF) ? timer_q : timer_q + 32'd1;
  assign w_timeout      = (w_timer_inc >= TIMEOUT);
  assign w_count_inc    = count_q + {9'd0, outen};
  assign w_grant_onehot = grant_q ? 2'b10 : 2'b01;

  assign ack         = (state_q == START || state_q == XFER) ? w_grant_onehot : 2'b00;
  assign rstart      = (state_q == START);
  assign rsector     = rsector_q;
  assign dout_strobe = strobe_q;
  assign dout        = dout_q;
  assign buff_addr   = baddr_q;
  assign err         = err_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    rsector_d = rsector_q;
    timer_d   = timer_q;
    count_d   = count_q;
    strobe_d  = 2'b00;
    dout_d    = dout_q;
    baddr_d   = baddr_q;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = 32'd0;
        if (rd != 2'b00) begin
          grant_d   = w_pick;
          rsector_d = w_pick ? lba1 : lba0;
          count_d   = 10'd0;
          state_d   = START;
        end
      end
      START: begin
        timer_d = w_timer_inc;
        if (w_timeout) begin
          state_d = DONE;
          timer_d = 32'd0;
          err_d   = 1'b1;
        end else if (rbusy) begin
          state_d = XFER;
          timer_d = 32'd0;
        end
      end
      XFER: begin
        timer_d = w_timer_inc;
        if (outen) begin
          strobe_d = w_grant_onehot;
          dout_d   = outbyte;
          baddr_d  = outaddr;
          count_d  = w_count_inc;
        end
        // A byte arriving with rdone is counted before the length check.
        if (rdone || w_timeout) begin
          state_d = DONE;
          timer_d = 32'd0;
          err_d   = w_timeout || (w_count_inc != 10'd512);
        end
      end
      DONE: begin
        timer_d = 32'd0;
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      rsector_q <= 32'd0;
      timer_q   <= 32'd0;
      count_q   <= 10'd0;
      strobe_q  <= 2'b00;
      dout_q    <= 8'd0;
      baddr_q   <= 9'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      rsector_q <= rsector_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
      strobe_q  <= strobe_d;
      dout_q    <= dout_d;
      baddr_q   <= baddr_d;
      err_q     <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_sector_arbiter.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_sd_sector_arbiter
// Description : Self-checking bench for sd_sector_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_sector_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  rd = 2'b00;
  logic [31:0] lba0 = 32'd0, lba1 = 32'd0;
  logic        rbusy = 1'b0, rdone = 1'b0, outen = 1'b0;
  logic [8:0]  outaddr = 9'd0;
  logic [7:0]  outbyte = 8'd0;

  logic [1:0]  ack, dout_strobe, ack_t, dout_strobe_t;
  logic [7:0]  dout, dout_t;
  logic [8:0]  buff_addr, buff_addr_t;
  logic        err, rstart, err_t, rstart_t;
  logic [31:0] rsector, rsector_t;

  int n_checks = 0;
  int n_fail   = 0;
  int model_last = 1;

  logic [1:0]  obs_ack[512], obs_strobe[512];
  logic [7:0]  obs_dout[512], sent_byte[512];
  logic [8:0]  obs_addr[512];
  int          obs_spurious, obs_err_early, s_start_bad;
  logic [1:0]  s_ack_start, s_ack_xfer;
  logic        s_rstart_start, s_rstart_xfer;
  logic [31:0] s_rsector;

  sd_sector_arbiter dut (
    .clk(clk), .reset_n(reset_n), .rd(rd), .lba0(lba0), .lba1(lba1),
    .ack(ack), .dout_strobe(dout_strobe), .dout(dout), .buff_addr(buff_addr),
    .err(err), .rstart(rstart), .rsector(rsector), .rbusy(rbusy), .rdone(rdone),
    .outen(outen), .outaddr(outaddr), .outbyte(outbyte)
  );

  sd_sector_arbiter #(.TIMEOUT(32'd100)) dut_t (
    .clk(clk), .reset_n(reset_n), .rd(rd), .lba0(lba0), .lba1(lba1),
    .ack(ack_t), .dout_strobe(dout_strobe_t), .dout(dout_t), .buff_addr(buff_addr_t),
    .err(err_t), .rstart(rstart_t), .rsector(rsector_t), .rbusy(rbusy), .rdone(rdone),
    .outen(outen), .outaddr(outaddr), .outbyte(outbyte)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, got still running required finished");
    $fatal(1, "simulation time limit");
  end

  // Reference rules: tie goes to the requester not served last.
  function automatic int pick(input logic [1:0] r);
    if (r == 2'b11) return 1 - model_last;
    return r[1] ? 1 : 0;
  endfunction

  function automatic logic [1:0] onehot(input int g);
    return (g == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; rd = 2'b00; outen = 1'b0; rdone = 1'b0; rbusy = 1'b0;
    step(); step();
    reset_n = 1'b1;
    model_last = 1;
  endtask

  // Grant edge, optional START wait with junk strobes, then rbusy into XFER.
  task automatic start_xfer(input int delay);
    obs_spurious = 0; obs_err_early = 0; s_start_bad = 0;
    step();
    s_ack_start = ack; s_rstart_start = rstart; s_rsector = rsector;
    for (int d = 0; d < delay; d++) begin
      outen = 1'($urandom); outbyte = 8'($urandom); outaddr = 9'($urandom);
      step();
      if (rstart !== 1'b1 || ack !== s_ack_start) s_start_bad++;
      if (dout_strobe !== 2'b00) obs_spurious++;
      if (err !== 1'b0) obs_err_early++;
    end
    outen = 1'b0; rbusy = 1'b1;
    step();
    s_ack_xfer = ack; s_rstart_xfer = rstart;
    if (dout_strobe !== 2'b00) obs_spurious++;
  endtask

  // mode 0: rdone after last byte, 1: rdone with last byte, 2: no rdone.
  task automatic drive_bytes(input int n, input int mode, input int gapmax);
    for (int i = 0; i < n; i++) begin
      outen = 1'b1; outbyte = 8'($urandom); outaddr = i[8:0];
      sent_byte[i] = outbyte;
      rdone = (mode == 1) && (i == n - 1);
      if (rdone) rbusy = 1'b0;
      step();
      outen = 1'b0; rdone = 1'b0;
      obs_ack[i] = ack; obs_strobe[i] = dout_strobe;
      obs_dout[i] = dout; obs_addr[i] = buff_addr;
      if (!(mode == 1 && i == n - 1)) begin
        if (err !== 1'b0) obs_err_early++;
        repeat ($urandom_range(gapmax, 0)) begin
          step();
          if (dout_strobe !== 2'b00) obs_spurious++;
          if (err !== 1'b0) obs_err_early++;
        end
      end
    end
    if (mode == 0) begin
      rdone = 1'b1; rbusy = 1'b0;
      step();
      rdone = 1'b0;
      if (dout_strobe !== 2'b00) obs_spurious++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rd = 2'b11; outen = 1'b1; rbusy = 1'b1; rdone = 1'b1;
    lba0 = $urandom; lba1 = $urandom; outbyte = 8'hA5; outaddr = 9'h1FF;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if ({ack, dout_strobe, err, rstart, rsector, dout, buff_addr} !== 55'd0) begin
        n_fail++;
        $display("FAIL reset_hold: got %h required 0", {ack, dout_strobe, err, rstart, rsector, dout, buff_addr});
      end
    end
    outen = 1'b0; rbusy = 1'b0; rdone = 1'b0; reset_n = 1'b1; model_last = 1;
    step();
    n_checks++;
    if ({ack, rstart, rsector} !== {onehot(pick(2'b11)), 1'b1, lba0}) begin
      n_fail++;
      $display("FAIL reset_first_grant: got %b/%b/%h required %b/1/%h", ack, rstart, rsector, onehot(pick(2'b11)), lba0);
    end
    apply_reset();
  endtask

  task automatic test_single_read();
    int bad;
    apply_reset();
    rd = 2'b01; lba0 = 32'h10; lba1 = $urandom;
    start_xfer(3);
    n_checks++;
    if ({s_ack_start, s_rstart_start, s_rsector, s_start_bad} !== {2'b01, 1'b1, 32'h10, 32'd0}) begin
      n_fail++;
      $display("FAIL single_start: got ack %b rstart %b rsector %h bad %0d required 01/1/10/0", s_ack_start, s_rstart_start, s_rsector, s_start_bad);
    end
    n_checks++;
    if ({s_ack_xfer, s_rstart_xfer} !== 3'b010) begin
      n_fail++;
      $display("FAIL single_xfer_entry: got ack %b rstart %b required 01/0", s_ack_xfer, s_rstart_xfer);
    end
    lba0 = $urandom;
    drive_bytes(512, 0, 2);
    bad = 0;
    for (int i = 0; i < 512; i++)
      if ({obs_ack[i], obs_strobe[i], obs_dout[i], obs_addr[i]} !== {2'b01, 2'b01, sent_byte[i], i[8:0]}) bad++;
    n_checks++;
    if (bad != 0 || obs_spurious != 0 || obs_err_early != 0) begin
      n_fail++;
      $display("FAIL single_bytes: got %0d bad, %0d spurious, %0d early err required 0/0/0", bad, obs_spurious, obs_err_early);
    end
    n_checks++;
    if ({ack, err, rsector} !== {2'b00, 1'b0, 32'h10}) begin
      n_fail++;
      $display("FAIL single_done: got ack %b err %b rsector %h required 00/0/10", ack, err, rsector);
    end
    model_last = 0;
    rd = 2'b00; outen = 1'b1;
    step();
    step();
    outen = 1'b0;
    n_checks++;
    if ({dout_strobe, err, ack} !== 5'd0) begin
      n_fail++;
      $display("FAIL single_ignore_done_idle: got strobe %b err %b ack %b required 00/0/00", dout_strobe, err, ack);
    end
  endtask

  task automatic test_fairness();
    int g; logic [31:0] exp_sec;
    apply_reset();
    rd = 2'b11;
    for (int t = 0; t < 3; t++) begin
      lba0 = $urandom; lba1 = $urandom;
      g = pick(2'b11);
      exp_sec = (g == 1) ? lba1 : lba0;
      start_xfer($urandom_range(3, 0));
      lba0 = $urandom; lba1 = $urandom;
      n_checks++;
      if ({s_ack_start, s_rsector} !== {onehot(g), exp_sec} || g != t % 2) begin
        n_fail++;
        $display("FAIL fair_grant%0d: got ack %b rsector %h required %b/%h", t, s_ack_start, s_rsector, onehot(g), exp_sec);
      end
      drive_bytes(512, 1, 0);
      n_checks++;
      if ({ack, err, rsector} !== {2'b00, 1'b0, exp_sec}) begin
        n_fail++;
        $display("FAIL fair_done%0d: got ack %b err %b rsector %h required 00/0/%h", t, ack, err, rsector, exp_sec);
      end
      model_last = g;
      step();
    end
  endtask

  task automatic test_short();
    int bad;
    apply_reset();
    rd = 2'b10; lba1 = $urandom;
    start_xfer(1);
    drive_bytes(500, 0, 1);
    bad = 0;
    for (int i = 0; i < 500; i++)
      if ({obs_ack[i], obs_strobe[i], obs_dout[i], obs_addr[i]} !== {2'b10, 2'b10, sent_byte[i], i[8:0]}) bad++;
    n_checks++;
    if (bad != 0 || obs_spurious != 0 || obs_err_early != 0) begin
      n_fail++;
      $display("FAIL short_bytes: got %0d bad, %0d spurious, %0d early err required 0/0/0", bad, obs_spurious, obs_err_early);
    end
    n_checks++;
    if ({ack, err} !== 3'b001) begin
      n_fail++;
      $display("FAIL short_err: got ack %b err %b required 00/1", ack, err);
    end
    model_last = 1;
    step();
    n_checks++;
    if ({ack, err, rstart} !== 4'b0000) begin
      n_fail++;
      $display("FAIL short_idle: got ack %b err %b rstart %b required 00/0/0", ack, err, rstart);
    end
    step();
    n_checks++;
    if ({ack, rstart} !== {onehot(pick(rd)), 1'b1}) begin
      n_fail++;
      $display("FAIL short_regrant: got ack %b rstart %b required %b/1", ack, rstart, onehot(pick(rd)));
    end
  endtask

  task automatic test_same_cycle();
    int bad;
    apply_reset();
    rd = 2'b01; lba0 = $urandom;
    start_xfer(0);
    drive_bytes(512, 1, 0);
    bad = 0;
    for (int i = 0; i < 511; i++)
      if ({obs_ack[i], obs_strobe[i], obs_dout[i], obs_addr[i]} !== {2'b01, 2'b01, sent_byte[i], i[8:0]}) bad++;
    n_checks++;
    if (bad != 0 || obs_spurious != 0 || obs_err_early != 0) begin
      n_fail++;
      $display("FAIL same_bytes: got %0d bad, %0d spurious, %0d early err required 0/0/0", bad, obs_spurious, obs_err_early);
    end
    n_checks++;
    if ({obs_strobe[511], obs_dout[511], obs_addr[511], ack, err} !== {2'b01, sent_byte[511], 9'd511, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL same_last: got strobe %b dout %h addr %0d ack %b err %b required 01/%h/511/00/0",
               obs_strobe[511], obs_dout[511], obs_addr[511], ack, err, sent_byte[511]);
    end
  endtask

  task automatic test_timeout();
    int cnt;
    apply_reset();
    rd = 2'b01;
    step();
    cnt = 0;
    while (rstart_t === 1'b1 && cnt < 300) begin
      cnt++;
      step();
    end
    n_checks++;
    if (cnt != 100 || {ack_t, err_t} !== 3'b001) begin
      n_fail++;
      $display("FAIL timeout_start: got %0d cycles ack %b err %b required 100/00/1", cnt, ack_t, err_t);
    end
    rd = 2'b00;
    step();
    n_checks++;
    if ({ack_t, err_t, rstart_t} !== 4'b0000) begin
      n_fail++;
      $display("FAIL timeout_idle: got ack %b err %b rstart %b required 00/0/0", ack_t, err_t, rstart_t);
    end
    apply_reset();
    rd = 2'b01; rbusy = 1'b1;
    step();
    step();
    cnt = 0;
    while (ack_t === 2'b01 && cnt < 300) begin
      cnt++;
      step();
    end
    n_checks++;
    if (cnt != 100 || err_t !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_xfer: got %0d cycles err %b required 100/1", cnt, err_t);
    end
    rbusy = 1'b0;
  endtask

  task automatic test_reset_mid_xfer();
    apply_reset();
    rd = 2'b01; lba0 = $urandom; lba1 = $urandom;
    start_xfer(0);
    drive_bytes(512, 1, 0);
    model_last = 0;
    step();
    start_xfer(1);
    drive_bytes(200, 2, 0);
    reset_n = 1'b0; outen = 1'b1; outbyte = 8'h5A;
    step();
    n_checks++;
    if ({ack, dout_strobe, err, rstart, rsector, dout, buff_addr} !== 55'd0) begin
      n_fail++;
      $display("FAIL midreset_zero: got %h required 0", {ack, dout_strobe, err, rstart, rsector, dout, buff_addr});
    end
    reset_n = 1'b1; outen = 1'b0; rbusy = 1'b0; rd = 2'b11; model_last = 1;
    step();
    n_checks++;
    if ({ack, rstart, rsector} !== {onehot(pick(2'b11)), 1'b1, lba0}) begin
      n_fail++;
      $display("FAIL midreset_grant: got ack %b rstart %b rsector %h required %b/1/%h", ack, rstart, rsector, onehot(pick(2'b11)), lba0);
    end
  endtask

  task automatic test_random();
    int g, n, mode, bad; logic [31:0] exp_sec; logic [1:0] ea;
    apply_reset();
    for (int t = 0; t < 6; t++) begin
      rd = 2'($urandom_range(3, 1)); lba0 = $urandom; lba1 = $urandom;
      g = pick(rd);
      exp_sec = (g == 1) ? lba1 : lba0;
      n = ($urandom_range(3, 0) == 0) ? $urandom_range(511, 1) : 512;
      mode = $urandom_range(1, 0);
      start_xfer($urandom_range(4, 0));
      if ($urandom_range(1, 0) == 1) rd = 2'b00;
      lba0 = $urandom; lba1 = $urandom;
      drive_bytes(n, mode, 1);
      bad = 0;
      for (int i = 0; i < n; i++) begin
        ea = (mode == 1 && i == n - 1) ? 2'b00 : onehot(g);
        if ({obs_ack[i], obs_strobe[i], obs_dout[i], obs_addr[i]} !== {ea, onehot(g), sent_byte[i], i[8:0]}) bad++;
      end
      n_checks++;
      if ({s_ack_start, s_rsector} !== {onehot(g), exp_sec} || bad != 0 || obs_spurious != 0 || obs_err_early != 0) begin
        n_fail++;
        $display("FAIL rand%0d_xfer: got ack %b rsector %h bad %0d spur %0d early %0d required %b/%h/0/0/0",
                 t, s_ack_start, s_rsector, bad, obs_spurious, obs_err_early, onehot(g), exp_sec);
      end
      n_checks++;
      if ({ack, err, rsector} !== {2'b00, (n != 512), exp_sec}) begin
        n_fail++;
        $display("FAIL rand%0d_done: got ack %b err %b rsector %h required 00/%b/%h", t, ack, err, rsector, (n != 512), exp_sec);
      end
      model_last = g;
      rd = 2'b00;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_fairness();
    test_short();
    test_same_cycle();
    test_timeout();
    test_reset_mid_xfer();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
